write_test_sequencer: RTL and testbench

Sequences the 32-bit write-path pattern generator for one host-initiated write test. It latches the pattern and word count, seeds the generator, and issues generator-enable pulses under downstream FIFO backpressure. It produces FIFO write strobes aligned to the generator's registered output and reports busy, done and error status. It sits between the host command registers and the generator/FIFO pair.

---
 rtl/write_test_sequencer.sv | 124 ++++++++++++
 tb/tb_write_test_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_test_sequencer.sv
// Write-test sequencer: seeds the 32-bit pattern generator, paces its enables
// against FIFO backpressure and emits FIFO write strobes aligned to generator data.
module write_test_sequencer #(
  parameter int CNT_W        = 32,
  parameter int NUM_PATTERNS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      pattern_sel,
  input  logic [CNT_W-1:0] word_count,
  input  logic             fifo_almost_full,
  output logic [31:0]      gen_pattern,
  output logic             gen_reset,
  output logic             gen_enable,
  output logic             fifo_wr,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, SEED, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pattern_q, pattern_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] written_q, written_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      written_q <= '0;
      fifo_wr_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      count_q   <= count_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      fifo_wr_q <= fifo_wr_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    count_d   = count_q;
    issued_d  = issued_q;
    written_d = written_q;
    done_d    = 1'b0;
    error_d   = error_q;

    // almost_full leaves room for the single word that may already be in flight
    gen_enable = (state_q == RUN) && (issued_q < count_q) && !fifo_almost_full && !abort;
    gen_reset  = (state_q == SEED) && !abort;
    fifo_wr_d  = gen_enable;

    if (fifo_wr_q) begin
      written_d = written_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (pattern_sel >= 32'(NUM_PATTERNS)) begin
            error_d = 1'b1;
          end else if (word_count == '0) begin
            done_d  = 1'b1;
            error_d = 1'b0;
          end else begin
            pattern_d = pattern_sel;
            count_d   = word_count;
            issued_d  = '0;
            written_d = '0;
            error_d   = 1'b0;
            state_d   = SEED;
          end
        end
      end
      SEED: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gen_enable) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_q + CNT_W'(1) == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // the last write strobe lands in this cycle; completion is reported one cycle later
        state_d = IDLE;
        done_d  = !abort;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gen_pattern   = pattern_q;
  assign fifo_wr       = fifo_wr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = written_q;

endmodule

// File: tb/tb_write_test_sequencer.sv
// Bench for write_test_sequencer: transaction-level model plus an external generator
// model; every cycle's outputs are compared and directed scenarios pin exact timing.
module tb_write_test_sequencer;

  localparam int CNT_W = 32;
  localparam int LOGN  = 8192;
  localparam int K_RST = 0, K_EN = 1, K_WR = 2, K_DONE = 3, K_BUSY = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      pattern_sel = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             fifo_almost_full = 1'b0;
  logic [31:0]      gen_pattern;
  logic             gen_reset, gen_enable, fifo_wr, busy, done, error;
  logic [CNT_W-1:0] words_written;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  write_test_sequencer #(.CNT_W(CNT_W), .NUM_PATTERNS(3)) dut (
    .clk(clk), .reset(rst), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .word_count(word_count),
    .fifo_almost_full(fifo_almost_full), .gen_pattern(gen_pattern),
    .gen_reset(gen_reset), .gen_enable(gen_enable), .fifo_wr(fifo_wr),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // k-th word of each pattern, straight from the pattern definitions
  function automatic logic [31:0] pat(input logic [31:0] p, input int unsigned k);
    logic [7:0] b;
    b = 8'(4 * k);
    case (p)
      32'd0:   return {b + 8'd3, b + 8'd2, b + 8'd1, b};
      32'd1:   return 32'(k);
      default: return 32'd1 << (k % 32);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Generator living downstream of the sequencer: data is registered on enable
  logic [31:0] gdata;
  int unsigned gidx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gdata <= '0;
      gidx  <= 0;
    end else if (gen_reset) begin
      gidx <= 0;
    end else if (gen_enable) begin
      gdata <= pat(gen_pattern, gidx);
      gidx  <= gidx + 1;
    end
  end

  // Transaction model: a test is active, first spends one seeding cycle, then
  // issues words until the count is reached, then spends one cycle finishing.
  bit          m_busy, m_seeded, m_prev_en, m_done, m_err;
  logic [31:0] m_pattern, m_count, m_issued, m_written;
  bit          exp_en, exp_rst;

  always_comb begin
    exp_en  = 1'b0;
    exp_rst = 1'b0;
    if (m_busy && !abort) begin
      exp_rst = !m_seeded;
      exp_en  = m_seeded && (m_issued < m_count) && !fifo_almost_full;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_seeded <= 0; m_prev_en <= 0; m_done <= 0; m_err <= 0;
      m_pattern <= '0; m_count <= '0; m_issued <= '0; m_written <= '0;
    end else begin
      m_prev_en <= exp_en;
      m_done    <= 1'b0;
      if (m_prev_en) m_written <= m_written + 1;
      if (!m_busy) begin
        if (start && !abort) begin
          if (pattern_sel > 32'd2) m_err <= 1'b1;
          else if (word_count == 0) begin
            m_done <= 1'b1;
            m_err  <= 1'b0;
          end else begin
            m_busy <= 1'b1; m_seeded <= 1'b0; m_err <= 1'b0;
            m_pattern <= pattern_sel; m_count <= word_count;
            m_issued <= '0; m_written <= '0;
          end
        end
      end else if (abort) m_busy <= 1'b0;
      else if (!m_seeded) m_seeded <= 1'b1;
      else if (m_issued == m_count) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else if (exp_en) m_issued <= m_issued + 1;
    end
  end

  // per-cycle log of DUT activity used by the directed timing checks
  bit          lg [5][LOGN];
  logic [31:0] lg_data [LOGN];

  always @(negedge clk) begin
    if (!rst) begin
      chk("gen_reset", 64'(gen_reset), 64'(exp_rst));
      chk("gen_enable", 64'(gen_enable), 64'(exp_en));
      chk("fifo_wr", 64'(fifo_wr), 64'(m_prev_en));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("error", 64'(error), 64'(m_err));
      chk("words_written", 64'(words_written), 64'(m_written));
      chk("gen_pattern", 64'(gen_pattern), 64'(m_pattern));
      if (fifo_wr) chk("gen_data", 64'(gdata), 64'(pat(m_pattern, m_written)));
    end
    if (cyc < LOGN) begin
      lg[K_RST][cyc] = gen_reset; lg[K_EN][cyc] = gen_enable; lg[K_WR][cyc] = fifo_wr;
      lg[K_DONE][cyc] = done; lg[K_BUSY][cyc] = busy; lg_data[cyc] = gdata;
    end
  end

  function automatic int cnt(input int k, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi && c < LOGN; c++) if (lg[k][c]) n++;
    return n;
  endfunction

  function automatic int first(input int k, input int lo, input int hi);
    for (int c = lo; c <= hi && c < LOGN; c++) if (lg[k][c]) return c;
    return -1;
  endfunction

  function automatic int last(input int k, input int lo, input int hi);
    int r = -1;
    for (int c = lo; c <= hi && c < LOGN; c++) if (lg[k][c]) r = c;
    return r;
  endfunction

  // data of the i-th write strobe inside the window
  function automatic logic [31:0] wdata(input int lo, input int hi, input int i);
    int n = 0;
    for (int c = lo; c <= hi && c < LOGN; c++) begin
      if (lg[K_WR][c]) begin
        if (n == i) return lg_data[c];
        n++;
      end
    end
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [31:0] sel, input logic [CNT_W-1:0] wc, output int s);
    pattern_sel = sel;
    word_count  = wc;
    start       = 1'b1;
    s           = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic check_basic4(input int s, input string tag);
    chk({tag, "_seed_cycle"}, 64'(first(K_RST, s, s + 12)), 64'(s + 1));
    chk({tag, "_en_first"}, 64'(first(K_EN, s, s + 12)), 64'(s + 2));
    chk({tag, "_en_last"}, 64'(last(K_EN, s, s + 12)), 64'(s + 5));
    chk({tag, "_wr_first"}, 64'(first(K_WR, s, s + 12)), 64'(s + 3));
    chk({tag, "_wr_last"}, 64'(last(K_WR, s, s + 12)), 64'(s + 6));
    chk({tag, "_busy_first"}, 64'(first(K_BUSY, s, s + 12)), 64'(s + 1));
    chk({tag, "_busy_last"}, 64'(last(K_BUSY, s, s + 12)), 64'(s + 6));
    chk({tag, "_done_cycle"}, 64'(first(K_DONE, s, s + 12)), 64'(s + 7));
    chk({tag, "_done_count"}, 64'(cnt(K_DONE, s, s + 12)), 64'd1);
    for (int i = 0; i < 4; i++) chk({tag, "_data"}, 64'(wdata(s, s + 12, i)), 64'(i));
    chk({tag, "_words_written"}, 64'(words_written), 64'd4);
  endtask

  initial begin
    int s;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pattern", 64'(gen_pattern), 64'd0);
    chk("reset_words", 64'(words_written), 64'd0);
    chk("reset_error", 64'(error), 64'd0);

    // pattern 1, four words, no backpressure
    start_cmd(32'd1, 4, s);
    repeat (10) tick();
    check_basic4(s, "p1x4");

    // pattern 0, three words, two-cycle stall right after the first enable
    start_cmd(32'd0, 3, s);
    tick();
    tick();
    fifo_almost_full = 1'b1;
    tick();
    tick();
    fifo_almost_full = 1'b0;
    repeat (8) tick();
    chk("stall_en_first", 64'(first(K_EN, s, s + 14)), 64'(s + 2));
    chk("stall_en_last", 64'(last(K_EN, s, s + 14)), 64'(s + 6));
    chk("stall_wr_count", 64'(cnt(K_WR, s, s + 14)), 64'd3);
    chk("stall_done_count", 64'(cnt(K_DONE, s, s + 14)), 64'd1);
    chk("stall_data0", 64'(wdata(s, s + 14, 0)), 64'h0302_0100);
    chk("stall_data1", 64'(wdata(s, s + 14, 1)), 64'h0706_0504);
    chk("stall_data2", 64'(wdata(s, s + 14, 2)), 64'h0B0A_0908);

    // walking one over 33 words wraps back to bit 0
    start_cmd(32'd2, 33, s);
    repeat (40) tick();
    chk("walk_first", 64'(wdata(s, s + 40, 0)), 64'h1);
    chk("walk_bit31", 64'(wdata(s, s + 40, 31)), 64'h8000_0000);
    chk("walk_wrap", 64'(wdata(s, s + 40, 32)), 64'h1);
    chk("walk_words", 64'(words_written), 64'd33);

    // bad pattern code, then a zero-length command
    start_cmd(32'd5, 4, s);
    repeat (3) tick();
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_busy", 64'(cnt(K_BUSY, s, s + 3)), 64'd0);
    chk("bad_seed", 64'(cnt(K_RST, s, s + 3)), 64'd0);
    start_cmd(32'd1, 0, s);
    repeat (3) tick();
    chk("zero_error", 64'(error), 64'd0);
    chk("zero_done", 64'(first(K_DONE, s, s + 3)), 64'(s + 1));
    chk("zero_en", 64'(cnt(K_EN, s, s + 3)), 64'd0);

    // stray start while busy, then abort right after the second enable
    start_cmd(32'd1, 10, s);
    tick();
    pattern_sel = 32'd0; word_count = 7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    chk("abort_wr", 64'(cnt(K_WR, s, s + 10)), 64'd2);
    chk("abort_words", 64'(words_written), 64'd2);
    chk("abort_done", 64'(cnt(K_DONE, s, s + 10)), 64'd0);
    chk("abort_busy_last", 64'(last(K_BUSY, s, s + 10)), 64'(s + 4));
    chk("abort_pattern", 64'(gen_pattern), 64'd1);

    // asynchronous reset between edges in the middle of a run
    start_cmd(32'd1, 20, s);
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_enable", 64'(gen_enable), 64'd0);
    chk("arst_fifo_wr", 64'(fifo_wr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_words", 64'(words_written), 64'd0);
    chk("arst_pattern", 64'(gen_pattern), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    start_cmd(32'd1, 4, s);
    repeat (10) tick();
    check_basic4(s, "post_arst");

    // randomized commands with random backpressure, stray starts and aborts
    for (int t = 0; t < 30; t++) begin
      logic [31:0] sel;
      sel = ($urandom % 8 < 6) ? $urandom_range(0, 2) : $urandom_range(3, 9);
      start_cmd(sel, CNT_W'($urandom_range(0, 40)), s);
      for (int i = 0; i < 300; i++) begin
        fifo_almost_full = ($urandom % 3 == 0);
        abort = ($urandom % 60 == 0);
        start = ($urandom % 20 == 0);
        pattern_sel = $urandom_range(0, 3);
        word_count = CNT_W'($urandom_range(0, 8));
        tick();
        if (i > 2 && !busy) break;
      end
      start = 1'b0; abort = 1'b0; fifo_almost_full = 1'b0;
      chk("rand_timeout_busy", 64'(busy), 64'd0);
      repeat (2) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
